shot_sched: RTL and testbench

- Player-fire controller sitting between the fire input and a pool of NSLOT player-bullet datapath slots. Each slot is a mover/hit-detector that flies one bullet upward and retires it on a hit or at the top boundary.
- Arbitrates the fire request onto a free slot using round-robin allocation.
- Enforces a refire cooldown and latches the launch position from the plane.
- Tracks slot occupancy from launch/retire events and recalls all bullets when the game is disabled.

---
 rtl/shot_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/shot_sched.sv | 130 +++++++++++++
 tb/tb_shot_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
// Shared definitions for the player-bullet pool: FSM encoding, defaults and
// screen limits that the bullet datapaths also use.
package shot_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_COOL   = 2'd2
   } state_t;

   localparam int DEF_NSLOT    = 4;
   localparam int DEF_COOLDOWN = 100;

   localparam int SCREEN_TOP   = 71;
   localparam int HIT_HALF_W   = 15;
   localparam int HIT_HALF_H   = 18;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: grants the first set bit of free_i,
// searching from ptr_i upward and wrapping at N.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  free_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic          any_free_o
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_i) + k) % N);
         if (!found && free_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   assign any_free_o = |free_i;

endmodule

// File: rtl/shot_sched.sv
// Player-fire controller: allocates fire requests onto free bullet slots,
// enforces the refire cooldown and recalls all bullets when the game stops.
module shot_sched
   import shot_pkg::*;
#(
   parameter int NSLOT    = DEF_NSLOT,
   parameter int COOLDOWN = DEF_COOLDOWN,
   parameter int CW       = 7
) (
   input  logic             clk_1ms,
   input  logic             rst,
   input  logic             enable,
   input  logic             fire,
   input  logic [9:0]       planex,
   input  logic [9:0]       planey,
   input  logic [NSLOT-1:0] retire,
   output logic [NSLOT-1:0] launch,
   output logic [9:0]       launchx,
   output logic [9:0]       launchy,
   output logic [NSLOT-1:0] busy,
   output logic             recall,
   output logic             cooling,
   output logic             stall,
   output logic [15:0]      shots
);

   localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

   state_t           state_q;
   logic [NSLOT-1:0] busy_q, launch_q, busy_d, free_d, grant_d;
   logic             any_free_d;
   logic [PW-1:0]    ptr_q, slot_q, slot_d, ptr_d;
   logic [CW-1:0]    cnt_q;
   logic [15:0]      shots_q;
   logic [9:0]       launchx_q, launchy_q;
   logic             recall_q, cooling_q, stall_q, en_q;

   // Same-edge retires free their slot for this cycle's allocation.
   assign busy_d = busy_q & ~retire;
   assign free_d = ~busy_d;

   rr_pick #(.N(NSLOT), .PW(PW)) u_pick (
      .free_i     (free_d),
      .ptr_i      (ptr_q),
      .grant_o    (grant_d),
      .any_free_o (any_free_d)
   );

   always_comb begin
      slot_d = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (grant_d[i]) slot_d = PW'(i);
      end
   end

   assign ptr_d = (slot_q == PW'(NSLOT - 1)) ? '0 : slot_q + PW'(1);

   always_ff @(posedge clk_1ms or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= '0;
         launch_q  <= '0;
         ptr_q     <= '0;
         slot_q    <= '0;
         cnt_q     <= '0;
         shots_q   <= '0;
         launchx_q <= '0;
         launchy_q <= '0;
         recall_q  <= 1'b0;
         cooling_q <= 1'b0;
         stall_q   <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         en_q      <= enable;
         recall_q  <= en_q & ~enable;
         launch_q  <= '0;
         stall_q   <= 1'b0;
         cooling_q <= 1'b0;
         if (!enable) begin
            // Game stopped: park everything; shots is deliberately kept.
            state_q <= S_IDLE;
            busy_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
         end else begin
            busy_q <= busy_d;
            unique case (state_q)
               S_IDLE: begin
                  if (fire && any_free_d) begin
                     launch_q  <= grant_d;
                     busy_q    <= busy_d | grant_d;
                     slot_q    <= slot_d;
                     launchx_q <= planex;
                     launchy_q <= planey;
                     state_q   <= S_LAUNCH;
                  end else begin
                     stall_q <= fire & ~any_free_d;
                  end
               end
               S_LAUNCH: begin
                  ptr_q     <= ptr_d;
                  shots_q   <= sat_inc16(shots_q);
                  cnt_q     <= CW'(COOLDOWN - 1);
                  cooling_q <= 1'b1;
                  state_q   <= S_COOL;
               end
               S_COOL: begin
                  if (cnt_q == '0) begin
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q     <= cnt_q - CW'(1);
                     cooling_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign launch  = launch_q;
   assign launchx = launchx_q;
   assign launchy = launchy_q;
   assign busy    = busy_q;
   assign recall  = recall_q;
   assign cooling = cooling_q;
   assign stall   = stall_q;
   assign shots   = shots_q;

endmodule

// File: tb/tb_shot_sched.sv
// Directed bench for shot_sched with NSLOT=4, COOLDOWN=3: a cycle table for
// allocation/stall/retire, then hand sequences for cooldown, enable drop,
// async reset and shot-count saturation.
module tb_shot_sched;

   logic        clk_1ms = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        fire = 1'b0;
   logic [9:0]  planex = '0, planey = '0;
   logic [3:0]  retire = '0;
   logic [3:0]  launch, busy;
   logic [9:0]  launchx, launchy;
   logic        recall, cooling, stall;
   logic [15:0] shots;

   int tests = 0;
   int fails = 0;

   shot_sched #(.NSLOT(4), .COOLDOWN(3), .CW(7)) dut (
      .clk_1ms (clk_1ms),
      .rst     (rst),
      .enable  (enable),
      .fire    (fire),
      .planex  (planex),
      .planey  (planey),
      .retire  (retire),
      .launch  (launch),
      .launchx (launchx),
      .launchy (launchy),
      .busy    (busy),
      .recall  (recall),
      .cooling (cooling),
      .stall   (stall),
      .shots   (shots)
   );

   always #5 clk_1ms = ~clk_1ms;

   typedef struct {
      logic        fire;
      logic [3:0]  ret;
      logic [9:0]  px, py;
      logic [3:0]  e_launch, e_busy;
      logic        e_stall, e_cool;
      logic [15:0] e_shots;
      logic [9:0]  e_lx, e_ly;
   } vec_t;

   vec_t tbl [0:24];

   function automatic vec_t mk(input logic f, input logic [3:0] r, input logic [9:0] px,
                               input logic [9:0] py, input logic [3:0] el, input logic [3:0] eb,
                               input logic es, input logic ec, input logic [15:0] esh,
                               input logic [9:0] elx, input logic [9:0] ely);
      vec_t v;
      v.fire = f; v.ret = r; v.px = px; v.py = py;
      v.e_launch = el; v.e_busy = eb; v.e_stall = es; v.e_cool = ec;
      v.e_shots = esh; v.e_lx = elx; v.e_ly = ely;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic en, input logic f, input logic [3:0] r);
      enable = en;
      fire   = f;
      retire = r;
      @(posedge clk_1ms);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; fire = 1'b0; retire = '0;
      @(negedge clk_1ms);
      @(negedge clk_1ms);
      rst = 1'b0;
   endtask

   logic [3:0] seen;

   initial begin
      // Launch every 5 cycles on slots 0..3, stall when full, retire then refill.
      tbl[0]  = mk(1, 4'b0000, 320, 400, 4'b0001, 4'b0001, 0, 0, 0, 320, 400);
      tbl[1]  = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0001, 0, 1, 1, 320, 400);
      tbl[2]  = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0001, 0, 1, 1, 320, 400);
      tbl[3]  = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0001, 0, 1, 1, 320, 400);
      tbl[4]  = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0001, 0, 0, 1, 320, 400);
      tbl[5]  = mk(1, 4'b0000, 320, 400, 4'b0010, 4'b0011, 0, 0, 1, 320, 400);
      tbl[6]  = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0011, 0, 1, 2, 320, 400);
      tbl[7]  = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0011, 0, 1, 2, 320, 400);
      tbl[8]  = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0011, 0, 1, 2, 320, 400);
      tbl[9]  = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0011, 0, 0, 2, 320, 400);
      tbl[10] = mk(1, 4'b0000, 320, 400, 4'b0100, 4'b0111, 0, 0, 2, 320, 400);
      tbl[11] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0111, 0, 1, 3, 320, 400);
      tbl[12] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0111, 0, 1, 3, 320, 400);
      tbl[13] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0111, 0, 1, 3, 320, 400);
      tbl[14] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b0111, 0, 0, 3, 320, 400);
      tbl[15] = mk(1, 4'b0000, 320, 400, 4'b1000, 4'b1111, 0, 0, 3, 320, 400);
      tbl[16] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b1111, 0, 1, 4, 320, 400);
      tbl[17] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b1111, 0, 1, 4, 320, 400);
      tbl[18] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b1111, 0, 1, 4, 320, 400);
      tbl[19] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b1111, 0, 0, 4, 320, 400);
      tbl[20] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b1111, 1, 0, 4, 320, 400);
      tbl[21] = mk(1, 4'b0000, 320, 400, 4'b0000, 4'b1111, 1, 0, 4, 320, 400);
      tbl[22] = mk(0, 4'b0100, 320, 400, 4'b0000, 4'b1011, 0, 0, 4, 320, 400);
      tbl[23] = mk(1, 4'b0000, 123, 456, 4'b0100, 4'b1111, 0, 0, 4, 123, 456);
      tbl[24] = mk(0, 4'b0000, 123, 456, 4'b0000, 4'b1111, 0, 1, 5, 123, 456);

      // Reset state while rst is held.
      #3;
      chk("rst_launch", 32'(launch), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_shots", 32'(shots), 0);
      chk("rst_recall", 32'(recall), 0);
      do_reset();

      for (int i = 0; i <= 24; i++) begin
         planex = tbl[i].px;
         planey = tbl[i].py;
         cyc(1'b1, tbl[i].fire, tbl[i].ret);
         $display("[TB] row %0d launch=%b busy=%b stall=%b cool=%b shots=%0d lx=%0d ly=%0d",
                  i, launch, busy, stall, cooling, shots, launchx, launchy);
         chk($sformatf("tbl%0d_launch", i), 32'(launch), 32'(tbl[i].e_launch));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d_cool", i), 32'(cooling), 32'(tbl[i].e_cool));
         chk($sformatf("tbl%0d_shots", i), 32'(shots), 32'(tbl[i].e_shots));
         chk($sformatf("tbl%0d_lx", i), 32'(launchx), 32'(tbl[i].e_lx));
         chk($sformatf("tbl%0d_ly", i), 32'(launchy), 32'(tbl[i].e_ly));
         chk($sformatf("tbl%0d_recall", i), 32'(recall), 0);
      end

      // Fire pulse during COOL must not be queued.
      do_reset();
      planex = 10'd77; planey = 10'd88;
      cyc(1, 1, 0);
      chk("cool_first_launch", 32'(launch), 32'h1);
      cyc(1, 0, 0);
      cyc(1, 1, 0);
      seen = '0;
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 0);
         seen |= launch;
      end
      $display("[TB] cool-fire: launches seen after cooldown=%b", seen);
      chk("cool_no_queue", 32'(seen), 0);
      planex = 10'd500; planey = 10'd9;
      cyc(1, 1, 0);
      $display("[TB] idle-fire: launch=%b lx=%0d ly=%0d", launch, launchx, launchy);
      chk("idle_fire_launch", 32'(launch), 32'h2);
      chk("idle_fire_lx", 32'(launchx), 500);
      chk("idle_fire_ly", 32'(launchy), 9);

      // Enable drop mid-COOL, then mid-LAUNCH.
      cyc(1, 0, 0);
      chk("pre_drop_shots", 32'(shots), 2);
      cyc(0, 1, 0);
      $display("[TB] drop-cool: recall=%b busy=%b cool=%b shots=%0d", recall, busy, cooling, shots);
      chk("dropc_recall", 32'(recall), 1);
      chk("dropc_busy", 32'(busy), 0);
      chk("dropc_cool", 32'(cooling), 0);
      chk("dropc_shots", 32'(shots), 2);
      cyc(0, 1, 4'b0011);
      chk("dropc_recall_once", 32'(recall), 0);
      chk("dropc_no_launch", 32'(launch), 0);
      chk("dropc_no_stall", 32'(stall), 0);
      cyc(1, 1, 0);
      chk("reen_launch_slot0", 32'(launch), 32'h1);
      chk("reen_busy", 32'(busy), 32'h1);
      cyc(0, 0, 0);
      $display("[TB] drop-launch: recall=%b busy=%b launch=%b shots=%0d", recall, busy, launch, shots);
      chk("dropl_recall", 32'(recall), 1);
      chk("dropl_busy", 32'(busy), 0);
      chk("dropl_launch", 32'(launch), 0);
      chk("dropl_shots", 32'(shots), 2);
      cyc(1, 0, 0);
      chk("dropl_recall_once", 32'(recall), 0);
      chk("dropl_cool", 32'(cooling), 0);

      // Async reset between edges mid-COOL.
      cyc(1, 1, 0);
      cyc(1, 0, 0);
      chk("prerst_cool", 32'(cooling), 1);
      chk("prerst_shots", 32'(shots), 3);
      #2 rst = 1'b1;
      #1;
      $display("[TB] async-rst: shots=%0d busy=%b cool=%b lx=%0d", shots, busy, cooling, launchx);
      chk("arst_shots", 32'(shots), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_cool", 32'(cooling), 0);
      chk("arst_lx", 32'(launchx), 0);
      @(negedge clk_1ms);
      rst = 1'b0;

      // Saturation of the shot counter.
      force dut.shots_q = 16'hFFFE;
      #1;
      release dut.shots_q;
      for (int n = 0; n < 3; n++) begin
         cyc(1, 1, 0);
         cyc(1, 0, 0);
         $display("[TB] sat launch %0d: shots=%h", n, shots);
         chk($sformatf("sat_shots%0d", n), 32'(shots), 32'hFFFF);
         cyc(1, 0, 0);
         cyc(1, 0, 0);
         cyc(1, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
